// File: rtl/stage_sink.sv
// Terminal consumer for the DOR/DIR/ack handshake: captures one word per handshake
// into a small FIFO, pulses ack_prev, and keeps a running checksum and word count.
module stage_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DIR,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_prev,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic [15:0]      word_count,
    output logic [WIDTH-1:0] checksum
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACK       = 2'd1;
    localparam logic [1:0] WAIT_DROP = 2'd2;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             capture;
    logic             pop;

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // full uses the pre-edge count, so a same-edge pop never unblocks a capture
    assign capture = (state == IDLE) && DIR && !full;
    assign pop     = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ack_prev <= 1'b0;
        end else begin
            ack_prev <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        ack_prev <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK:       state <= WAIT_DROP;
                WAIT_DROP: if (!DIR) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Storage is data-only; stale contents are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (reset && capture) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            if (capture) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= word_count + 16'd1;
                checksum   <= wrap_add(checksum, data_in);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_stage_sink.sv
// Bench for stage_sink: directed handshake scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_stage_sink;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             DIR;
    logic [WIDTH-1:0] data_in;
    logic             ack_prev;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic [15:0]      word_count;
    logic [WIDTH-1:0] checksum;

    always #5 clk = ~clk;

    stage_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in), .ack_prev(ack_prev),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .full(full), .count(count), .word_count(word_count), .checksum(checksum)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of stored words plus a "may capture" flag.
    logic [WIDTH-1:0] q[$];
    bit               m_ready;
    int               m_since;
    logic [WIDTH-1:0] m_sum;
    logic [15:0]      m_wc;
    logic             m_ack;
    logic             m_rv;
    logic [WIDTH-1:0] m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit cap;
        bit pp;
        if (!reset) begin
            q.delete();
            m_ready = 1'b1;
            m_since = 0;
            m_sum   = '0;
            m_wc    = '0;
            m_ack   = 1'b0;
            m_rv    = 1'b0;
            m_rd    = '0;
        end else begin
            cap = DIR && m_ready && (q.size() < DEPTH);
            pp  = rd_en && (q.size() > 0);
            m_rv = pp;
            if (pp) m_rd = q.pop_front();
            m_ack = cap;
            if (cap) begin
                q.push_back(data_in);
                m_sum   = m_sum + data_in;
                m_wc    = m_wc + 16'd1;
                m_ready = 1'b0;
                m_since = 0;
            end else if (!m_ready) begin
                // one acknowledge cycle, then wait until DIR is seen low
                m_since++;
                if (m_since >= 2 && !DIR) m_ready = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("ack_prev", 32'(ack_prev), 32'(m_ack));
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("word_count", 32'(word_count), 32'(m_wc));
        check("checksum", 32'(checksum), 32'(m_sum));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        DIR = 1'b1;
        data_in = d;
        step();
        step();
        DIR = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; DIR = 1'b1; rd_en = 1'b1; data_in = 8'hAA;
        m_ready = 1'b1; m_since = 0; m_sum = '0; m_wc = '0;
        m_ack = 1'b0; m_rv = 1'b0; m_rd = '0;

        // reset held with activity on the inputs
        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        reset = 1'b1; DIR = 1'b0; rd_en = 1'b0;
        step();

        // single transfer then read
        DIR = 1'b1; data_in = 8'h05;
        step();
        check("single_ack", 32'(ack_prev), 32'd1);
        step();
        DIR = 1'b0;
        step();
        step();
        check("single_sum", 32'(checksum), 32'h05);
        rd_en = 1'b1;
        step();
        check("single_rd", 32'(rd_data), 32'h05);
        rd_en = 1'b0;
        step();
        check("single_empty", 32'(empty), 32'd1);

        // level-held DIR gives one capture
        DIR = 1'b1; data_in = 8'h33;
        repeat (6) step();
        check("held_wc", 32'(word_count), 32'd2);
        check("held_count", 32'(count), 32'd1);
        DIR = 1'b0;
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;

        // backpressure
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("bp_full", 32'(full), 32'd1);
        DIR = 1'b1; data_in = 8'h05;
        repeat (5) begin
            step();
            check("bp_noack", 32'(ack_prev), 32'd0);
        end
        rd_en = 1'b1;
        step();
        check("bp_rd", 32'(rd_data), 32'h01);
        rd_en = 1'b0;
        step();
        check("bp_ack", 32'(ack_prev), 32'd1);
        check("bp_count", 32'(count), 32'd4);
        DIR = 1'b0;
        step();
        step();
        rd_en = 1'b1;
        repeat (4) step();
        rd_en = 1'b0;

        // checksum wrap from a fresh reset, then read past empty
        reset = 1'b0;
        step();
        reset = 1'b1;
        send(8'hF0);
        send(8'h20);
        check("wrap_sum", 32'(checksum), 32'h10);
        rd_en = 1'b1;
        step();
        check("pop1", 32'(rd_data), 32'hF0);
        step();
        check("pop2", 32'(rd_data), 32'h20);
        step();
        check("pop3_valid", 32'(rd_valid), 32'd0);
        check("pop3_hold", 32'(rd_data), 32'h20);
        rd_en = 1'b0;

        // reset in the middle of a handshake
        DIR = 1'b1; data_in = 8'h77;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        check("midrst_wc", 32'(word_count), 32'd0);
        reset = 1'b1;
        step();
        check("midrst_ack", 32'(ack_prev), 32'd1);
        check("midrst_wc1", 32'(word_count), 32'd1);
        DIR = 1'b0;
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) DIR = ~DIR;
            data_in = 8'($urandom);
            rd_en   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
